axi4_slave_wr_mem: RTL

Parametrised AXI4 write-channel slave memory model used as the RTL back-end of the slave agent in active mode. Accepts AW/W bursts (FIXED/INCR/WRAP, narrow transfers, byte strobes) and stores bytes in a local array sized in KB. It returns buffered B responses with OKAY/SLVERR/DECERR, and exposes a debug read port for scoreboard back-door checks.

---
 rtl/axi4_slave_wr_mem.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_slave_wr_mem.sv
// rtl/axi4_slave_wr_mem.sv - AXI4 write-channel slave memory model with buffered B responses
// Byte-array store written one W beat per cycle; responses queue in a small FIFO.
module axi4_slave_wr_mem #(
  parameter  int                AXI_DW            = 64,
  parameter  int                AXI_AW            = 32,
  parameter  int                AXI_IW            = 4,
  localparam int                AXI_SW            = AXI_DW / 8,
  parameter  int                SLAVE_MEMORY_SIZE = 12,
  parameter  logic [AXI_AW-1:0] SLAVE_BASE_ADDR   = '0,
  parameter  int                BRESP_DEPTH       = 2
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [AXI_IW-1:0] awid,
  input  logic [AXI_AW-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [AXI_DW-1:0] wdata,
  input  logic [AXI_SW-1:0] wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [AXI_IW-1:0] bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [AXI_AW-1:0] dbg_addr,
  output logic [AXI_DW-1:0] dbg_rdata
);

  localparam int MEM_BYTES = SLAVE_MEMORY_SIZE * 1024;
  localparam int IDX_W     = $clog2(MEM_BYTES);
  localparam int LOG_SW    = $clog2(AXI_SW);
  localparam int PW        = (BRESP_DEPTH > 1) ? $clog2(BRESP_DEPTH) : 1;
  localparam int CW        = $clog2(BRESP_DEPTH + 1);
  localparam logic [AXI_AW-1:0] ONE         = AXI_AW'(1);
  localparam logic [AXI_AW-1:0] MEM_BYTES_A = AXI_AW'(MEM_BYTES);
  localparam logic [AXI_AW-1:0] LANE_MASK   = AXI_AW'(AXI_SW - 1);
  localparam logic [2:0]        MAX_SIZE    = 3'(LOG_SW);

  typedef enum logic {S_IDLE, S_DATA} state_t;
  state_t r_state, w_state_n;

  logic [7:0] r_mem [0:MEM_BYTES-1];

  logic              r_awready, r_wready, r_bvalid;
  logic [AXI_IW-1:0] r_bid;
  logic [1:0]        r_bresp;
  logic [AXI_DW-1:0] r_dbg_rdata;

  logic [AXI_IW-1:0] r_id;
  logic [AXI_AW-1:0] r_addr, r_wrap_base, r_wrap_mask;
  logic [7:0]        r_len, r_cnt;
  logic [2:0]        r_size;
  logic              r_fixed, r_wrap, r_size_err, r_slverr, r_decerr;

  logic [AXI_IW+1:0] r_fifo [0:BRESP_DEPTH-1];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic              w_aw_hs, w_w_hs, w_last, w_push, w_pop;
  logic              w_beat_slverr, w_beat_decerr, w_size_err, w_wrap_ok;
  logic              w_awready_n, w_wready_n;
  logic [1:0]        w_resp;
  logic [AXI_AW-1:0] w_aw_mask, w_bytes, w_aligned, w_lane_base, w_lane_lo, w_lane_hi;
  logic [AXI_AW-1:0] w_next_lin, w_next_addr, w_dbg_base;
  logic [AXI_AW-1:0] w_off [AXI_SW];
  logic [AXI_AW-1:0] w_dbg_off [AXI_SW];
  logic [AXI_SW-1:0] w_lane_ok, w_in_range, w_we, w_dbg_in;
  logic [AXI_IW+1:0] w_push_data, w_head_n;
  logic [PW-1:0]     w_rd_ptr_n;
  logic [CW-1:0]     w_count_n;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BRESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_aw_hs = awvalid && r_awready && (r_state == S_IDLE) && !areset;
  assign w_w_hs  = wvalid && r_wready && (r_state == S_DATA) && !areset;

  always_comb begin
    w_aw_mask  = ((AXI_AW'(awlen) + ONE) << awsize) - ONE;
    w_size_err = awsize > MAX_SIZE;
    w_wrap_ok  = (awburst == 2'b10) &&
                 (awlen == 8'd1 || awlen == 8'd3 || awlen == 8'd7 || awlen == 8'd15) &&
                 ((awaddr & ((ONE << awsize) - ONE)) == '0);
  end

  // Per-lane decode of the current beat; an oversized beat only feeds the range check.
  always_comb begin
    w_bytes       = ONE << r_size;
    w_aligned     = r_addr & ~(w_bytes - ONE);
    w_lane_base   = r_addr & ~LANE_MASK;
    w_lane_lo     = r_addr & LANE_MASK;
    w_lane_hi     = r_size_err ? LANE_MASK : ((w_aligned + w_bytes - ONE) & LANE_MASK);
    w_beat_decerr = 1'b0;
    w_lane_ok     = '0;
    w_in_range    = '0;
    w_we          = '0;
    for (int j = 0; j < AXI_SW; j++) begin
      w_off[j]      = w_lane_base + AXI_AW'(j) - SLAVE_BASE_ADDR;
      w_in_range[j] = w_off[j] < MEM_BYTES_A;
      w_lane_ok[j]  = (AXI_AW'(j) >= w_lane_lo) && (AXI_AW'(j) <= w_lane_hi);
      if (w_lane_ok[j] && !w_in_range[j]) w_beat_decerr = 1'b1;
      w_we[j] = w_w_hs && w_lane_ok[j] && w_in_range[j] && wstrb[j] && !r_size_err;
    end
    w_next_lin = w_aligned + w_bytes;
    if (r_fixed)
      w_next_addr = r_addr;
    else if (r_wrap && ((w_next_lin & r_wrap_mask) == '0))
      w_next_addr = r_wrap_base;
    else
      w_next_addr = w_next_lin;
  end

  always_comb begin
    w_last        = wlast || (r_cnt == r_len);
    w_beat_slverr = wlast != (r_cnt == r_len);
    w_resp        = (r_decerr || w_beat_decerr) ? 2'b11 :
                    (r_slverr || w_beat_slverr) ? 2'b10 : 2'b00;
    w_push        = w_w_hs && w_last;
    w_push_data   = {r_id, w_resp};
    w_pop         = r_bvalid && bready;
    w_rd_ptr_n    = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    w_count_n     = r_count + CW'(w_push) - CW'(w_pop);
    // A push into an otherwise-empty queue becomes the head without a cycle of delay.
    w_head_n      = (w_push && (r_wr_ptr == w_rd_ptr_n)) ? w_push_data : r_fifo[w_rd_ptr_n];
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (w_aw_hs) w_state_n = S_DATA;
      S_DATA:  if (w_push)  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
    w_awready_n = (w_state_n == S_IDLE) && (w_count_n < CW'(BRESP_DEPTH));
    w_wready_n  = (w_state_n == S_DATA);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state   <= S_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      r_state            <= w_state_n;
      r_awready          <= w_awready_n;
      r_wready           <= w_wready_n;
      r_bvalid           <= (w_count_n != '0);
      {r_bid, r_bresp}   <= (w_count_n != '0) ? w_head_n : '0;
      r_rd_ptr           <= w_rd_ptr_n;
      r_count            <= w_count_n;
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
    end
  end

  always_ff @(posedge aclk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_id        <= '0;
      r_addr      <= '0;
      r_wrap_base <= '0;
      r_wrap_mask <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_size      <= '0;
      r_fixed     <= 1'b0;
      r_wrap      <= 1'b0;
      r_size_err  <= 1'b0;
      r_slverr    <= 1'b0;
      r_decerr    <= 1'b0;
    end else if (w_aw_hs) begin
      r_id        <= awid;
      r_addr      <= awaddr;
      r_wrap_base <= awaddr & ~w_aw_mask;
      r_wrap_mask <= w_aw_mask;
      r_len       <= awlen;
      r_cnt       <= '0;
      r_size      <= awsize;
      r_fixed     <= (awburst == 2'b00);
      r_wrap      <= w_wrap_ok;
      r_size_err  <= w_size_err;
      r_slverr    <= w_size_err || (awburst == 2'b11) || ((awburst == 2'b10) && !w_wrap_ok);
      r_decerr    <= 1'b0;
    end else if (w_w_hs) begin
      r_addr   <= w_next_addr;
      r_cnt    <= r_cnt + 8'd1;
      r_slverr <= r_slverr || w_beat_slverr;
      r_decerr <= r_decerr || w_beat_decerr;
    end
  end

  always_ff @(posedge aclk) begin
    for (int j = 0; j < AXI_SW; j++)
      if (w_we[j]) r_mem[w_off[j][IDX_W-1:0]] <= wdata[8*j +: 8];
  end

  always_comb begin
    w_dbg_base = dbg_addr & ~LANE_MASK;
    w_dbg_in   = '0;
    for (int j = 0; j < AXI_SW; j++) begin
      w_dbg_off[j] = w_dbg_base + AXI_AW'(j) - SLAVE_BASE_ADDR;
      w_dbg_in[j]  = w_dbg_off[j] < MEM_BYTES_A;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_dbg_rdata <= '0;
    end else begin
      for (int j = 0; j < AXI_SW; j++)
        r_dbg_rdata[8*j +: 8] <= w_dbg_in[j] ? r_mem[w_dbg_off[j][IDX_W-1:0]] : 8'h00;
    end
  end

  assign awready   = r_awready;
  assign wready    = r_wready;
  assign bvalid    = r_bvalid;
  assign bid       = r_bid;
  assign bresp     = r_bresp;
  assign dbg_rdata = r_dbg_rdata;

endmodule
